// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the synchronous FIFO.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD,
    FIFO_FWFT
  } fifo_mode_e;

  // Occupancy counter needs one extra bit to represent a completely full FIFO.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_v2_if.sv
// Handshake and status bundle between a FIFO user (master) and the FIFO (slave).
interface sync_fifo_v2_if
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 8
) ();

  localparam int unsigned CNT_W = cnt_width(FIFO_DEPTH);

  logic                  flush;
  logic                  write;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  read;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, write, data_in, read,
    input  data_out, full, empty, almost_full, almost_empty, fifo_count, overflow, underflow
  );

  modport slave (
    input  flush, write, data_in, read,
    output data_out, full, empty, almost_full, almost_empty, fifo_count, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port register array: one synchronous write port, one asynchronous read port.
module fifo_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_v2.sv
// Synchronous FIFO with registered-read or first-word-fall-through output,
// occupancy-decoded status flags and sticky overflow/underflow.
module sync_fifo_v2
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned AF_LEVEL   = FIFO_DEPTH - 2,
  parameter int unsigned AE_LEVEL   = 2,
  parameter fifo_mode_e  MODE       = FIFO_STD
) (
  input logic           clk,
  input logic           rst,
  sync_fifo_v2_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = cnt_width(FIFO_DEPTH);

  if ((FIFO_DEPTH < 4) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_v2: FIFO_DEPTH must be a power of two and at least 4");
  end
  if (AE_LEVEL >= AF_LEVEL) begin : g_bad_levels
    $error("sync_fifo_v2: AE_LEVEL must be below AF_LEVEL");
  end

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  logic                  full, empty, rd_acc, wr_acc;
  logic [DATA_WIDTH-1:0] rd_data;

  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty = (count_q == '0);

  // Flush blocks both transfers; a write into a full FIFO rides on a same-cycle read.
  assign rd_acc = bus.read && !empty && !bus.flush;
  assign wr_acc = bus.write && (!full || rd_acc) && !bus.flush;

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (wr_acc && !rd_acc) count_d = count_q + CNT_W'(1);
      if (rd_acc && !wr_acc) count_d = count_q - CNT_W'(1);
      if (bus.write && !wr_acc) ovf_d = 1'b1;
      if (bus.read && !rd_acc) udf_d = 1'b1;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc && rst),
    .waddr (wr_ptr_q),
    .wdata (bus.data_in),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  if (MODE == FIFO_STD) begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;
    // Registered read: capture the head word as it is popped, hold otherwise.
    always_ff @(posedge clk) begin
      if (!rst) dout_q <= '0;
      else if (rd_acc) dout_q <= rd_data;
    end
    assign bus.data_out = dout_q;
  end else begin : g_fwft
    assign bus.data_out = rd_data;
  end

  assign bus.fifo_count   = count_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= CNT_W'(AF_LEVEL));
  assign bus.almost_empty = (count_q <= CNT_W'(AE_LEVEL));
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Bench for sync_fifo_v2: a registered-read and a FWFT instance see identical
// stimulus and are compared each cycle against a queue-based model.
module tb_sync_fifo_v2;
  import fifo_pkg::*;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_v2_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus_s ();
  sync_fifo_v2_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus_f ();

  sync_fifo_v2 #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MODE(FIFO_STD)) u_std (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  sync_fifo_v2 #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MODE(FIFO_FWFT)) u_fwft (
    .clk (clk),
    .rst (rst),
    .bus (bus_f)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: contents as a queue, plus the last popped word.
  logic [DW-1:0] q [$];
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;
  logic [DW-1:0] m_dout = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic rn, input logic fl, input logic w, input logic [DW-1:0] d,
                       input logic r);
    bit rd_ok, wr_ok;
    if (!rn) begin
      q.delete();
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      m_dout = '0;
    end else if (fl) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      rd_ok = r && (q.size() > 0);
      wr_ok = w && ((q.size() < DEPTH) || rd_ok);
      if (r && !rd_ok) m_udf = 1'b1;
      if (w && !wr_ok) m_ovf = 1'b1;
      if (rd_ok) m_dout = q.pop_front();
      if (wr_ok) q.push_back(d);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("std_count", 32'(bus_s.fifo_count), 32'(n));
    chk("std_full", 32'(bus_s.full), 32'(n == DEPTH));
    chk("std_empty", 32'(bus_s.empty), 32'(n == 0));
    chk("std_afull", 32'(bus_s.almost_full), 32'(n >= DEPTH - 2));
    chk("std_aempty", 32'(bus_s.almost_empty), 32'(n <= 2));
    chk("std_ovf", 32'(bus_s.overflow), 32'(m_ovf));
    chk("std_udf", 32'(bus_s.underflow), 32'(m_udf));
    chk("std_dout", 32'(bus_s.data_out), 32'(m_dout));
    chk("fwft_count", 32'(bus_f.fifo_count), 32'(n));
    chk("fwft_empty", 32'(bus_f.empty), 32'(n == 0));
    chk("fwft_ovf", 32'(bus_f.overflow), 32'(m_ovf));
    chk("fwft_udf", 32'(bus_f.underflow), 32'(m_udf));
    if (n > 0) chk("fwft_dout", 32'(bus_f.data_out), 32'(q[0]));
  endtask

  // One clock of stimulus: drive at negedge, model the edge, check at next negedge.
  task automatic step(input logic rn, input logic fl, input logic w, input logic [DW-1:0] d,
                      input logic r);
    rst           = rn;
    bus_s.flush   = fl;
    bus_f.flush   = fl;
    bus_s.write   = w;
    bus_f.write   = w;
    bus_s.data_in = d;
    bus_f.data_in = d;
    bus_s.read    = r;
    bus_f.read    = r;
    @(posedge clk);
    model(rn, fl, w, d, r);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    bus_s.flush = 1'b0; bus_f.flush = 1'b0;
    bus_s.write = 1'b0; bus_f.write = 1'b0;
    bus_s.read  = 1'b0; bus_f.read  = 1'b0;
    bus_s.data_in = '0; bus_f.data_in = '0;

    // Reset state.
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // Fill to full with 0x01..0x08, then one rejected write.
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 1'b1, 8'(i), 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'hEE, 1'b0);

    // Drain all eight, then one rejected read.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

    // Clear flags, refill, then read+write together on a full FIFO.
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 1'b1, 8'(8'h10 + i), 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'hAA, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

    // Read and write together on empty: write wins, underflow set.
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'h5C, 1'b1);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

    // Fill five, flush alongside a write, then a 12-word stream across pointer wrap.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 8'(8'h30 + i), 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'h99, 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'h40, 1'b0);
    for (int i = 1; i < 12; i++) step(1'b1, 1'b0, 1'b1, 8'(8'h40 + i), 1'b1);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

    // Mid-operation reset while writing discards contents and the write.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 8'(8'h60 + i), 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h77, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

    // Randomised traffic with phases biased toward filling and draining.
    for (int i = 0; i < 600; i++) begin
      int wbias;
      wbias = ((i / 50) % 2 == 0) ? 70 : 30;
      step(($urandom_range(0, 149) != 0),
           ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 99) < wbias),
           8'($urandom),
           ($urandom_range(0, 99) < (100 - wbias)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
